fetch_stage: RTL and testbench

- Instruction-fetch stage sitting directly upstream of the decode pipeline register.
- Owns the program counter and drives the program-memory read address.
- Registers the fetched instruction and its address toward decode.
- Stops sequential fetch after a control-transfer instruction (JR, JPC, CALL) and inserts bubbles until the resolved target arrives on the redirect interface.

---
 rtl/fetch_pkg.sv | 27 ++
 rtl/program_counter.sv | 34 +++
 rtl/fetch_stage.sv | 105 ++++++++++
 tb/tb_fetch_stage.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// ============================================================================
// Module      : fetch_pkg
// Description : Opcode constants, NOP and FSM encoding for the fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

    localparam logic [4:0]  OP_JR   = 5'b01101;
    localparam logic [4:0]  OP_JPC  = 5'b01110;
    localparam logic [4:0]  OP_CALL = 5'b10000;

    localparam logic [31:0] NOP     = 32'h0;

    typedef enum logic [0:0] {
        ST_RUN         = 1'b0,
        ST_WAIT_TARGET = 1'b1
    } state_t;

    function automatic logic is_transfer(input logic [4:0] op);
        return (op == OP_JR) || (op == OP_JPC) || (op == OP_CALL);
    endfunction

endpackage

`default_nettype wire

// File: rtl/program_counter.sv
// ============================================================================
// Module      : program_counter
// Description : PC register with async active-low reset, load, hold, increment.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module program_counter #(
    parameter int unsigned         DWIDTH     = 32,
    parameter logic [DWIDTH-1:0]   RESET_ADDR = '0,
    parameter logic [DWIDTH-1:0]   PC_STEP    = DWIDTH'(1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DWIDTH-1:0] load_addr,
    input  logic              advance,
    output logic [DWIDTH-1:0] pc
);

    // Load beats advance; neither means hold. The add wraps modulo 2^DWIDTH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= RESET_ADDR;
        end else if (load) begin
            pc <= load_addr;
        end else if (advance) begin
            pc <= pc + PC_STEP;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// Module      : fetch_stage
// Description : Instruction fetch with bubble insertion after control transfers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned         DWIDTH     = 32,
    parameter logic [DWIDTH-1:0]   RESET_ADDR = '0,
    parameter logic [DWIDTH-1:0]   PC_STEP    = DWIDTH'(1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [DWIDTH-1:0] redirect_addr,
    output logic [DWIDTH-1:0] imem_addr,
    input  logic [DWIDTH-1:0] imem_data,
    output logic [DWIDTH-1:0] addr,
    output logic [DWIDTH-1:0] inst,
    output logic              valid,
    output logic              wait_target
);

    state_t            state;
    state_t            state_nx;
    logic [DWIDTH-1:0] pc;
    logic              pc_advance;
    logic              take;
    logic              bubble;

    program_counter #(
        .DWIDTH     (DWIDTH),
        .RESET_ADDR (RESET_ADDR),
        .PC_STEP    (PC_STEP)
    ) u_pc (
        .clk       (clk),
        .rst       (rst),
        .load      (redirect_valid),
        .load_addr (redirect_addr),
        .advance   (pc_advance),
        .pc        (pc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_nx;
        end
    end

    // Redirect is a flush: it wins over stall and cancels a same-cycle transfer.
    always_comb begin
        state_nx   = state;
        pc_advance = 1'b0;
        take       = 1'b0;
        bubble     = 1'b0;
        if (redirect_valid) begin
            state_nx = ST_RUN;
            bubble   = 1'b1;
        end else if (!stall) begin
            case (state)
                ST_RUN: begin
                    pc_advance = 1'b1;
                    take       = 1'b1;
                    if (is_transfer(imem_data[31:27])) begin
                        state_nx = ST_WAIT_TARGET;
                    end
                end
                ST_WAIT_TARGET: begin
                    bubble = 1'b1;
                end
                default: begin
                    state_nx = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr  <= '0;
            inst  <= DWIDTH'(NOP);
            valid <= 1'b0;
        end else if (bubble) begin
            addr  <= '0;
            inst  <= DWIDTH'(NOP);
            valid <= 1'b0;
        end else if (take) begin
            addr  <= pc;
            inst  <= imem_data;
            valid <= 1'b1;
        end
    end

    assign imem_addr   = pc;
    assign wait_target = (state == ST_WAIT_TARGET);

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module      : tb_fetch_stage
// Description : Directed table-driven bench for fetch_stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] addr;
    logic [31:0] inst;
    logic        valid;
    logic        wait_target;

    int n_vec;
    int n_bad;

    typedef struct {
        logic        stall;
        logic        rv;
        logic [31:0] ra;
        logic [31:0] data;
        logic [31:0] e_imem;
        logic [31:0] e_addr;
        logic [31:0] e_inst;
        logic        e_valid;
        logic        e_wt;
    } vec_t;

    localparam int NVEC = 25;
    vec_t vecs [NVEC];

    fetch_stage #(
        .DWIDTH     (32),
        .RESET_ADDR (32'h0),
        .PC_STEP    (32'h1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .addr           (addr),
        .inst           (inst),
        .valid          (valid),
        .wait_target    (wait_target)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] ei, input logic [31:0] ea,
                         input logic [31:0] en, input logic ev, input logic ew);
        n_vec++;
        if (imem_addr !== ei || addr !== ea || inst !== en || valid !== ev || wait_target !== ew) begin
            n_bad++;
            $display("FAIL %s: got imem_addr=%h addr=%h inst=%h valid=%b wait_target=%b; want imem_addr=%h addr=%h inst=%h valid=%b wait_target=%b",
                     name, imem_addr, addr, inst, valid, wait_target, ei, ea, en, ev, ew);
        end
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;

        //          stall rv    ra            data            e_imem        e_addr        e_inst          v     wt
        // sequential fetch from reset
        vecs[0]  = '{1'b0, 1'b0, 32'h0,        32'h0800_0001, 32'h1,        32'h0,        32'h0800_0001, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 32'h0,        32'h0800_0001, 32'h2,        32'h1,        32'h0800_0001, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 32'h0,        32'h0800_0001, 32'h3,        32'h2,        32'h0800_0001, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 32'h0,        32'h0800_0001, 32'h4,        32'h3,        32'h0800_0001, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 32'h0,        32'h0800_0001, 32'h5,        32'h4,        32'h0800_0001, 1'b1, 1'b0};
        // JR at PC=5, three bubbles, redirect to 0x40
        vecs[5]  = '{1'b0, 1'b0, 32'h0,        32'h6800_1400, 32'h6,        32'h5,        32'h6800_1400, 1'b1, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 32'h0,        32'h0800_0001, 32'h6,        32'h0,        32'h0,         1'b0, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 32'h0,        32'h0800_0001, 32'h6,        32'h0,        32'h0,         1'b0, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 32'h0,        32'h0800_0001, 32'h6,        32'h0,        32'h0,         1'b0, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 32'h40,       32'h0800_0001, 32'h40,       32'h0,        32'h0,         1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 32'h0,        32'h0800_0040, 32'h41,       32'h40,       32'h0800_0040, 1'b1, 1'b0};
        // move to PC=9, then stall two cycles at PC=10
        vecs[11] = '{1'b0, 1'b1, 32'h9,        32'h0800_0041, 32'h9,        32'h0,        32'h0,         1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 32'h0,        32'h0800_0009, 32'hA,        32'h9,        32'h0800_0009, 1'b1, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 32'h0,        32'h0800_000A, 32'hA,        32'h9,        32'h0800_0009, 1'b1, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 32'h0,        32'h0800_000A, 32'hA,        32'h9,        32'h0800_0009, 1'b1, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 32'h0,        32'h0800_000A, 32'hB,        32'hA,        32'h0800_000A, 1'b1, 1'b0};
        // stall together with redirect: flush wins
        vecs[16] = '{1'b1, 1'b1, 32'h80,       32'h0800_000B, 32'h80,       32'h0,        32'h0,         1'b0, 1'b0};
        vecs[17] = '{1'b0, 1'b0, 32'h0,        32'h0800_0080, 32'h81,       32'h80,       32'h0800_0080, 1'b1, 1'b0};
        // CALL fetched while redirect to 0x20: transfer dropped, no bubble stream
        vecs[18] = '{1'b0, 1'b1, 32'h20,       32'h8000_0000, 32'h20,       32'h0,        32'h0,         1'b0, 1'b0};
        vecs[19] = '{1'b0, 1'b0, 32'h0,        32'h0800_0020, 32'h21,       32'h20,       32'h0800_0020, 1'b1, 1'b0};
        // PC wrap at all-ones
        vecs[20] = '{1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0800_0021, 32'hFFFF_FFFF, 32'h0,       32'h0,         1'b0, 1'b0};
        vecs[21] = '{1'b0, 1'b0, 32'h0,        32'h0800_0001, 32'h0,        32'hFFFF_FFFF, 32'h0800_0001, 1'b1, 1'b0};
        // JPC at PC=0, stall while waiting holds everything, then a bubble
        vecs[22] = '{1'b0, 1'b0, 32'h0,        32'h7000_0000, 32'h1,        32'h0,        32'h7000_0000, 1'b1, 1'b1};
        vecs[23] = '{1'b1, 1'b0, 32'h0,        32'h0800_0001, 32'h1,        32'h0,        32'h7000_0000, 1'b1, 1'b1};
        vecs[24] = '{1'b0, 1'b0, 32'h0,        32'h0800_0001, 32'h1,        32'h0,        32'h0,         1'b0, 1'b1};

        rst            = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr  = 32'h0;
        imem_data      = 32'h0800_0001;

        @(negedge clk);
        check("reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        check("release", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

        for (int i = 0; i < NVEC; i++) begin
            stall          = vecs[i].stall;
            redirect_valid = vecs[i].rv;
            redirect_addr  = vecs[i].ra;
            imem_data      = vecs[i].data;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), vecs[i].e_imem, vecs[i].e_addr,
                  vecs[i].e_inst, vecs[i].e_valid, vecs[i].e_wt);
        end

        // Async reset mid-cycle while in WAIT_TARGET, no clock edge in between
        stall          = 1'b0;
        redirect_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("async_rst", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

        @(negedge clk);
        rst       = 1'b1;
        imem_data = 32'h0800_0001;
        @(posedge clk);
        #1;
        check("post_rst", 32'h1, 32'h0, 32'h0800_0001, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
